// File: rtl/brick_field_renderer.sv
// Brick-wall renderer for a 640x480 breakout field: draws alive bricks on the
// delayed pixel stream and serves brick-hit requests through a small FSM.
module brick_field_renderer #(
  parameter int          NCOLS        = 10,
  parameter int          NROWS        = 5,
  parameter int          BRICK_W_LOG2 = 6,
  parameter int          BRICK_H_LOG2 = 4,
  parameter int          FIELD_TOP    = 32,
  parameter int          MORTAR       = 2,
  parameter logic [7:0]  BG_COLOR     = 8'h00
) (
  input  logic        pixel_clk,
  input  logic        rst,
  input  logic [10:0] hcounter,
  input  logic [10:0] vcounter,
  input  logic        blank,
  input  logic        HS,
  input  logic        VS,
  output logic [7:0]  rgb,
  output logic        HS_out,
  output logic        VS_out,
  output logic        blank_out,
  input  logic        hit_valid,
  output logic        hit_ready,
  input  logic [3:0]  hit_col,
  input  logic [2:0]  hit_row,
  output logic        hit_done,
  output logic        hit_alive,
  input  logic        load_level,
  output logic [5:0]  bricks_left,
  output logic        all_clear
);

  localparam int NB = NCOLS * NROWS;
  localparam logic [5:0]  NB_COUNT = 6'(NB);
  localparam logic [10:0] TOP_LINE = 11'(FIELD_TOP);
  localparam logic [10:0] FIELD_H  = 11'(NROWS << BRICK_H_LOG2);
  localparam logic [10:0] FIELD_W  = 11'(NCOLS << BRICK_W_LOG2);
  localparam logic [BRICK_W_LOG2-1:0] MORTAR_X = BRICK_W_LOG2'((1 << BRICK_W_LOG2) - MORTAR);
  localparam logic [BRICK_H_LOG2-1:0] MORTAR_Y = BRICK_H_LOG2'((1 << BRICK_H_LOG2) - MORTAR);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [10:0]   r_hc_d;
  logic [10:0]   r_vc_d;
  logic [7:0]    r_rgb;
  logic          r_hs;
  logic          r_vs;
  logic          r_blank;
  logic [NB-1:0] r_alive;
  logic [5:0]    r_bricks_left;
  logic          r_hit_alive;
  logic [3:0]    r_hit_col;
  logic [2:0]    r_hit_row;

  logic [10:0]   w_y;
  logic          w_in_field;
  logic          w_mortar;
  logic [3:0]    w_col;
  logic [2:0]    w_row;
  logic [6:0]    w_pix_idx;
  logic [127:0]  w_alive_pad;
  logic          w_pix_alive;
  logic [7:0]    w_row_color;
  logic [7:0]    w_rgb_next;
  logic [6:0]    w_hit_idx;
  logic          w_hit_in_range;
  logic [NB-1:0] w_hit_mask;
  logic          w_hit_target_alive;

  // Stage 1: delay counters so they line up with blank/HS/VS of the same pixel.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_hc_d <= '0;
      r_vc_d <= '0;
    end else begin
      r_hc_d <= hcounter;
      r_vc_d <= vcounter;
    end
  end

  assign w_y        = r_vc_d - TOP_LINE;
  assign w_in_field = (r_vc_d >= TOP_LINE) && (w_y < FIELD_H) && (r_hc_d < FIELD_W);
  assign w_mortar   = (r_hc_d[BRICK_W_LOG2-1:0] >= MORTAR_X) ||
                      (w_y[BRICK_H_LOG2-1:0] >= MORTAR_Y);
  assign w_col      = 4'(r_hc_d >> BRICK_W_LOG2);
  assign w_row      = 3'(w_y >> BRICK_H_LOG2);
  assign w_pix_idx  = 7'(int'(w_row) * NCOLS + int'(w_col));

  // Padding keeps the lookup in range for coordinates outside the field.
  assign w_alive_pad = 128'(r_alive);
  assign w_pix_alive = w_alive_pad[w_pix_idx];

  always_comb begin
    w_row_color = 8'hFF;
    case (w_row)
      3'd0:    w_row_color = 8'hE0;
      3'd1:    w_row_color = 8'hF0;
      3'd2:    w_row_color = 8'hFC;
      3'd3:    w_row_color = 8'h1C;
      3'd4:    w_row_color = 8'h03;
      default: w_row_color = 8'hFF;
    endcase
  end

  always_comb begin
    w_rgb_next = BG_COLOR;
    if (blank) begin
      w_rgb_next = 8'h00;
    end else if (w_in_field && !w_mortar && w_pix_alive) begin
      w_rgb_next = w_row_color;
    end
  end

  // Stage 2: colour and syncs leave together.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_rgb   <= 8'h00;
      r_hs    <= 1'b1;
      r_vs    <= 1'b1;
      r_blank <= 1'b1;
    end else begin
      r_rgb   <= w_rgb_next;
      r_hs    <= HS;
      r_vs    <= VS;
      r_blank <= blank;
    end
  end

  assign rgb       = r_rgb;
  assign HS_out    = r_hs;
  assign VS_out    = r_vs;
  assign blank_out = r_blank;

  assign w_hit_in_range = (int'(r_hit_col) < NCOLS) && (int'(r_hit_row) < NROWS);
  assign w_hit_idx      = 7'(int'(r_hit_row) * NCOLS + int'(r_hit_col));

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_hit_mask
      assign w_hit_mask[gi] = w_hit_in_range && (w_hit_idx == 7'(gi));
    end
  endgenerate

  assign w_hit_target_alive = |(r_alive & w_hit_mask);

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    hit_ready    = 1'b0;
    hit_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        hit_ready = 1'b1;
        if (hit_valid) begin
          w_state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        hit_done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_hit_col <= '0;
      r_hit_row <= '0;
    end else if (r_state == S_IDLE && hit_valid) begin
      r_hit_col <= hit_col;
      r_hit_row <= hit_row;
    end
  end

  // A reload wins over a pending clear; the requester still sees DONE.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      r_alive       <= '1;
      r_bricks_left <= NB_COUNT;
      r_hit_alive   <= 1'b0;
    end else if (load_level) begin
      r_alive       <= '1;
      r_bricks_left <= NB_COUNT;
      if (r_state == S_CHECK) begin
        r_hit_alive <= 1'b0;
      end
    end else if (r_state == S_CHECK) begin
      if (w_hit_target_alive) begin
        r_alive       <= r_alive & ~w_hit_mask;
        r_bricks_left <= r_bricks_left - 6'd1;
        r_hit_alive   <= 1'b1;
      end else begin
        r_hit_alive   <= 1'b0;
      end
    end
  end

  assign hit_alive   = r_hit_alive;
  assign bricks_left = r_bricks_left;
  assign all_clear   = (r_bricks_left == 6'd0);

endmodule

// File: tb/tb_brick_field_renderer.sv
// Directed bench for brick_field_renderer: pixel colours, sync alignment,
// hit handshake, reload priority and reset behaviour.
module tb_brick_field_renderer;

  logic        pixel_clk;
  logic        rst;
  logic [10:0] hcounter;
  logic [10:0] vcounter;
  logic        blank;
  logic        HS;
  logic        VS;
  logic [7:0]  rgb;
  logic        HS_out;
  logic        VS_out;
  logic        blank_out;
  logic        hit_valid;
  logic        hit_ready;
  logic [3:0]  hit_col;
  logic [2:0]  hit_row;
  logic        hit_done;
  logic        hit_alive;
  logic        load_level;
  logic [5:0]  bricks_left;
  logic        all_clear;

  int checks_cnt;
  int fail_cnt;

  brick_field_renderer dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .hcounter    (hcounter),
    .vcounter    (vcounter),
    .blank       (blank),
    .HS          (HS),
    .VS          (VS),
    .rgb         (rgb),
    .HS_out      (HS_out),
    .VS_out      (VS_out),
    .blank_out   (blank_out),
    .hit_valid   (hit_valid),
    .hit_ready   (hit_ready),
    .hit_col     (hit_col),
    .hit_row     (hit_row),
    .hit_done    (hit_done),
    .hit_alive   (hit_alive),
    .load_level  (load_level),
    .bricks_left (bricks_left),
    .all_clear   (all_clear)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s val=%0h", tag, got);
    end
  endtask

  // Counters presented in one cycle, blank one cycle later, rgb read after stage 2.
  task automatic probe(input logic [10:0] h, input logic [10:0] v, input logic bl,
                       input logic [7:0] exp, input string tag);
    @(posedge pixel_clk); #1;
    hcounter = h;
    vcounter = v;
    @(posedge pixel_clk); #1;
    blank = bl;
    @(posedge pixel_clk); #1;
    check_val(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!hit_ready && n < 20) begin
      @(posedge pixel_clk); #1;
      n++;
    end
    check_val({tag, "_ready"}, 32'(hit_ready), 32'd1);
  endtask

  task automatic do_hit(input logic [3:0] c, input logic [2:0] r, input logic exp_alive,
                        input logic [5:0] exp_left, input string tag);
    wait_ready(tag);
    hit_col   = c;
    hit_row   = r;
    hit_valid = 1'b1;
    @(posedge pixel_clk); #1;
    hit_valid = 1'b0;
    check_val({tag, "_busy1"}, 32'(hit_ready), 32'd0);
    check_val({tag, "_nodone"}, 32'(hit_done), 32'd0);
    @(posedge pixel_clk); #1;
    check_val({tag, "_busy2"}, 32'(hit_ready), 32'd0);
    check_val({tag, "_done"}, 32'(hit_done), 32'd1);
    check_val({tag, "_alive"}, 32'(hit_alive), 32'(exp_alive));
    check_val({tag, "_left"}, 32'(bricks_left), 32'(exp_left));
    @(posedge pixel_clk); #1;
    check_val({tag, "_donelow"}, 32'(hit_done), 32'd0);
    check_val({tag, "_alivehold"}, 32'(hit_alive), 32'(exp_alive));
  endtask

  initial begin
    logic [5:0] left;
    checks_cnt = 0;
    fail_cnt   = 0;
    rst        = 1'b1;
    hcounter   = '0;
    vcounter   = '0;
    blank      = 1'b0;
    HS         = 1'b1;
    VS         = 1'b1;
    hit_valid  = 1'b0;
    hit_col    = '0;
    hit_row    = '0;
    load_level = 1'b0;

    #1;
    check_val("rst_rgb", 32'(rgb), 32'h00);
    check_val("rst_hs", 32'(HS_out), 32'd1);
    check_val("rst_vs", 32'(VS_out), 32'd1);
    check_val("rst_blank", 32'(blank_out), 32'd1);
    check_val("rst_done", 32'(hit_done), 32'd0);
    check_val("rst_alive", 32'(hit_alive), 32'd0);
    check_val("rst_left", 32'(bricks_left), 32'd50);
    check_val("rst_clear", 32'(all_clear), 32'd0);
    check_val("rst_ready", 32'(hit_ready), 32'd1);
    repeat (2) @(posedge pixel_clk);
    #1 rst = 1'b0;

    probe(11'd100, 11'd40, 1'b0, 8'hE0, "pix_100_40");
    probe(11'd126, 11'd40, 1'b0, 8'h00, "pix_mortar_x");
    probe(11'd100, 11'd46, 1'b0, 8'h00, "pix_mortar_y");
    probe(11'd100, 11'd20, 1'b0, 8'h00, "pix_above");
    probe(11'd100, 11'd40, 1'b1, 8'h00, "pix_blank");
    probe(11'd100, 11'd50, 1'b0, 8'hF0, "pix_row1");
    probe(11'd10,  11'd70, 1'b0, 8'hFC, "pix_row2");
    probe(11'd200, 11'd85, 1'b0, 8'h1C, "pix_row3");
    probe(11'd300, 11'd100, 1'b0, 8'h03, "pix_row4");
    probe(11'd700, 11'd40, 1'b0, 8'h00, "pix_right");
    probe(11'd100, 11'd112, 1'b0, 8'h00, "pix_below");

    @(posedge pixel_clk); #1;
    HS = 1'b1; VS = 1'b1; blank = 1'b1;
    @(posedge pixel_clk); #1;
    check_val("sync_hs_pre", 32'(HS_out), 32'd1);
    check_val("sync_blank_pre", 32'(blank_out), 32'd1);
    HS = 1'b0; VS = 1'b0; blank = 1'b0;
    #3;
    check_val("sync_hs_same", 32'(HS_out), 32'd1);
    @(posedge pixel_clk); #1;
    check_val("sync_hs_fall", 32'(HS_out), 32'd0);
    check_val("sync_vs_fall", 32'(VS_out), 32'd0);
    check_val("sync_blank_fall", 32'(blank_out), 32'd0);
    HS = 1'b1; VS = 1'b1;

    do_hit(4'd1, 3'd0, 1'b1, 6'd49, "hit_1_0");
    probe(11'd100, 11'd40, 1'b0, 8'h00, "pix_cleared");
    probe(11'd20,  11'd40, 1'b0, 8'hE0, "pix_neighbour");
    do_hit(4'd1, 3'd0, 1'b0, 6'd49, "hit_again");
    do_hit(4'd12, 3'd0, 1'b0, 6'd49, "hit_oor_col");
    do_hit(4'd0, 3'd6, 1'b0, 6'd49, "hit_oor_row");

    // Reload landing on the CHECK cycle of a hit to a live brick.
    wait_ready("ld_chk");
    hit_col = 4'd2; hit_row = 3'd0; hit_valid = 1'b1;
    @(posedge pixel_clk); #1;
    hit_valid  = 1'b0;
    load_level = 1'b1;
    @(posedge pixel_clk); #1;
    load_level = 1'b0;
    check_val("ld_chk_done", 32'(hit_done), 32'd1);
    check_val("ld_chk_alive", 32'(hit_alive), 32'd0);
    check_val("ld_chk_left", 32'(bricks_left), 32'd50);
    probe(11'd150, 11'd40, 1'b0, 8'hE0, "ld_chk_drawn");
    probe(11'd100, 11'd40, 1'b0, 8'hE0, "ld_chk_restored");

    left = 6'd50;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 10; c++) begin
        left = left - 6'd1;
        do_hit(4'(c), 3'(r), 1'b1, left, $sformatf("clr_%0d_%0d", c, r));
      end
    end
    check_val("clr_left", 32'(bricks_left), 32'd0);
    check_val("clr_all", 32'(all_clear), 32'd1);
    probe(11'd100, 11'd40, 1'b0, 8'h00, "clr_pix_r0");
    probe(11'd300, 11'd100, 1'b0, 8'h00, "clr_pix_r4");
    do_hit(4'd9, 3'd4, 1'b0, 6'd0, "clr_no_underflow");

    @(posedge pixel_clk); #1;
    load_level = 1'b1;
    @(posedge pixel_clk); #1;
    load_level = 1'b0;
    check_val("load_left", 32'(bricks_left), 32'd50);
    check_val("load_clear", 32'(all_clear), 32'd0);
    probe(11'd300, 11'd100, 1'b0, 8'h03, "load_pix_r4");

    do_hit(4'd1, 3'd0, 1'b1, 6'd49, "pre_rst_hit");
    HS = 1'b0; VS = 1'b0;
    probe(11'd20, 11'd40, 1'b0, 8'hE0, "pre_rst_pix");
    hit_col = 4'd3; hit_row = 3'd0; hit_valid = 1'b1;
    @(posedge pixel_clk); #1;
    hit_valid = 1'b0;
    check_val("pre_rst_busy", 32'(hit_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    check_val("arst_ready", 32'(hit_ready), 32'd1);
    check_val("arst_left", 32'(bricks_left), 32'd50);
    check_val("arst_rgb", 32'(rgb), 32'h00);
    check_val("arst_hs", 32'(HS_out), 32'd1);
    check_val("arst_vs", 32'(VS_out), 32'd1);
    check_val("arst_blank", 32'(blank_out), 32'd1);
    check_val("arst_done", 32'(hit_done), 32'd0);
    @(posedge pixel_clk); #1;
    rst = 1'b0; HS = 1'b1; VS = 1'b1;
    probe(11'd100, 11'd40, 1'b0, 8'hE0, "post_rst_pix");

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule
